// File: rtl/cordic_engine_if.sv
// Operation handshake bundle for the CORDIC engine: input side (vector/angle offer)
// and output side (result offer), each with its own valid/ready pair.
interface cordic_engine_if #(
  parameter int W       = 16,
  parameter int ANGLE_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic [W-1:0]       x_in;
  logic [W-1:0]       y_in;
  logic [ANGLE_W-1:0] angle_in;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       x_out;
  logic [W-1:0]       y_out;
  logic [ANGLE_W-1:0] angle_out;

  modport master (
    output in_valid, mode, x_in, y_in, angle_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, angle_out
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, angle_in, out_ready,
    output in_ready, out_valid, x_out, y_out, angle_out
  );
endinterface

// File: rtl/cordic_engine.sv
// Iterative CORDIC (rotation/vectoring), one op in flight; result valid ITER+2 edges after accept.
// Result held until consumed; new input accepted only while idle (in_ready = IDLE).
module cordic_engine #(
  parameter int W         = 16,
  parameter int ANGLE_W   = 16,
  parameter int ITER      = 16,
  parameter int GAIN_COMP = 1
) (
  input logic         clk,
  input logic         reset_n,
  cordic_engine_if.slave bus
);

  localparam int XW     = W + 2;
  localparam int PW     = 2 * W + 3;
  localparam int ITER_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [ANGLE_W-1:0] HALF = {1'b1, {(ANGLE_W-1){1'b0}}};
  localparam logic signed [PW-1:0] KC   = PW'($rtoi(0.6072529350 * (2.0 ** (W - 1)) + 0.5));
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (W - 2);
  localparam logic signed [PW-1:0] MAXP = (PW'(1) <<< (W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] NEGP = -MAXP;

  typedef enum logic [2:0] {IDLE, PRE, ROT, SCALE, DONE} state_t;

  function automatic logic [ANGLE_W-1:0] atan_code(input int i);
    real r;
    r = $atan(2.0 ** (-i)) / (2.0 * 3.14159265358979323846) * (2.0 ** ANGLE_W);
    return ANGLE_W'($rtoi(r + 0.5));
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXP)      return MAXP[W-1:0];
    else if (v < NEGP) return NEGP[W-1:0];
    else               return v[W-1:0];
  endfunction

  logic [ANGLE_W-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    assign atan_tab[g] = atan_code(g);
  end

  state_t                state;
  logic [ITER_W-1:0]     iter;
  logic                  vec_mode;
  logic signed [XW-1:0]  x, y;
  logic [ANGLE_W-1:0]    z;

  logic signed [XW-1:0]  xs, ys;
  logic                  d_pos;
  logic signed [PW-1:0]  px, py;

  always_comb begin
    xs    = x >>> iter;
    ys    = y >>> iter;
    d_pos = vec_mode ? y[XW-1] : ~z[ANGLE_W-1];
    px    = PW'(x);
    py    = PW'(y);
    // Round-half-up: add half an LSB of the Q1.(W-1) product before the shift.
    if (GAIN_COMP != 0) begin
      px = (PW'(x) * KC + RND) >>> (W - 1);
      py = (PW'(y) * KC + RND) >>> (W - 1);
    end
  end

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      iter          <= '0;
      vec_mode      <= 1'b0;
      x             <= '0;
      y             <= '0;
      z             <= '0;
      bus.out_valid <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.angle_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vec_mode <= bus.mode;
            x        <= {{2{bus.x_in[W-1]}}, bus.x_in};
            y        <= {{2{bus.y_in[W-1]}}, bus.y_in};
            z        <= bus.angle_in;
            state    <= PRE;
          end
        end
        PRE: begin
          // Fold onto the right half-plane so the micro-rotations can converge.
          if (vec_mode) begin
            if (x[XW-1]) begin
              x <= -x;
              y <= -y;
              z <= HALF;
            end else begin
              z <= '0;
            end
          end else if (z[ANGLE_W-1] != z[ANGLE_W-2]) begin
            x <= -x;
            y <= -y;
            z <= z - HALF;
          end
          iter  <= '0;
          state <= ROT;
        end
        ROT: begin
          if (d_pos) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan_tab[iter];
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan_tab[iter];
          end
          if (iter == ITER_W'(ITER - 1)) state <= SCALE;
          else                           iter  <= iter + 1'b1;
        end
        SCALE: begin
          bus.x_out     <= sat(px);
          bus.y_out     <= sat(py);
          bus.angle_out <= z;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed-vector bench for cordic_engine (W=16, ANGLE_W=16, ITER=16, gain compensated).
module tb_cordic_engine;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] r_x, r_y, r_a;
  int          r_lat;

  always #5 clk = ~clk;

  cordic_engine_if #(.W(16), .ANGLE_W(16)) bus ();

  cordic_engine #(.W(16), .ANGLE_W(16), .ITER(16), .GAIN_COMP(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Wrap-aware tolerance compare on 16-bit values.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                     input int tol = 0);
    logic signed [15:0] diff;
    int                 mag;
    diff  = obs - exp;
    mag   = (diff < 0) ? -int'(diff) : int'(diff);
    n_cmp++;
    if ($isunknown(obs) || mag > tol) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic start_op(input logic m, input logic [15:0] xi, input logic [15:0] yi,
                          input logic [15:0] ai);
    for (int k = 0; k < 100 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("accept_rdy", 16'(bus.in_ready), 16'd1);
    bus.mode     = m;
    bus.x_in     = xi;
    bus.y_in     = yi;
    bus.angle_in = ai;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    r_lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      r_lat++;
      if (bus.out_valid) break;
    end
    chk("latency", 16'(r_lat), 16'd18);
    r_x = bus.x_out;
    r_y = bus.y_out;
    r_a = bus.angle_out;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic m, input logic [15:0] xi, input logic [15:0] yi,
                        input logic [15:0] ai);
    start_op(m, xi, yi, ai);
    wait_done();
    consume();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode     = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.angle_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  16'(bus.in_ready),  16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_x_out",     bus.x_out,          16'h0000);
    chk("rst_y_out",     bus.y_out,          16'h0000);
    chk("rst_angle_out", bus.angle_out,      16'h0000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Rotation by 45 deg: 0.5*cos45 = 0x2D41
    run_op(1'b0, 16'h4000, 16'h0000, 16'h2000);
    chk("rot45_x", r_x, 16'h2D41, 4);
    chk("rot45_y", r_y, 16'h2D41, 4);
    chk("rot45_a", r_a, 16'h0000, 4);
    chk("idle_after_consume", 16'(bus.in_ready), 16'd1);

    // Rotation by 180 deg (quadrant fold)
    run_op(1'b0, 16'h4000, 16'h0000, 16'h8000);
    chk("rot180_x", r_x, 16'hC000, 4);
    chk("rot180_y", r_y, 16'h0000, 4);
    chk("rot180_a", r_a, 16'h0000, 4);

    // Rotation by 270 deg (-90)
    run_op(1'b0, 16'h4000, 16'h0000, 16'hC000);
    chk("rot270_x", r_x, 16'h0000, 4);
    chk("rot270_y", r_y, 16'hC000, 4);

    // Vectoring 3-4-5 triangle; angle_in must be ignored
    run_op(1'b1, 16'h3000, 16'h4000, 16'h1234);
    chk("vec345_mag", r_x, 16'h5000, 4);
    chk("vec345_y",   r_y, 16'h0000, 4);
    chk("vec345_ang", r_a, 16'h25C8, 4);

    // Vectoring with negative x
    run_op(1'b1, 16'hC000, 16'h0000, 16'h0000);
    chk("vecneg_mag", r_x, 16'h4000, 4);
    chk("vecneg_ang", r_a, 16'h8000, 4);

    // Vectoring saturation: |(0x7FFF,0x7FFF)| > full scale
    run_op(1'b1, 16'h7FFF, 16'h7FFF, 16'h0000);
    chk("vecsat_mag", r_x, 16'h7FFF);
    chk("vecsat_ang", r_a, 16'h2000, 4);

    // Backpressure: result held while in_valid pulses with new data
    start_op(1'b0, 16'h4000, 16'h0000, 16'h2000);
    wait_done();
    for (int c = 0; c < 5; c++) begin
      bus.mode     = 1'b1;
      bus.x_in     = 16'h3000;
      bus.y_in     = 16'h4000;
      bus.in_valid = (c % 2 == 0);
      @(posedge clk); #1;
      chk("bp_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_ready", 16'(bus.in_ready),  16'd0);
      chk("bp_x",     bus.x_out,          16'h2D41, 4);
      chk("bp_y",     bus.y_out,          16'h2D41, 4);
    end
    bus.in_valid = 1'b0;
    consume();
    chk("bp_rel_ready", 16'(bus.in_ready),  16'd1);
    chk("bp_rel_valid", 16'(bus.out_valid), 16'd0);
    @(posedge clk); #1;
    chk("bp_no_accept", 16'(bus.in_ready), 16'd1);

    // Reset mid-operation at ROT i=7
    start_op(1'b0, 16'h4000, 16'h0000, 16'h8000);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mid_rst_ready", 16'(bus.in_ready),  16'd1);
    chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_x",     bus.x_out,          16'h0000);
    chk("mid_rst_y",     bus.y_out,          16'h0000);
    chk("mid_rst_a",     bus.angle_out,      16'h0000);
    run_op(1'b1, 16'h3000, 16'h4000, 16'h0000);
    chk("post_rst_mag", r_x, 16'h5000, 4);
    chk("post_rst_ang", r_a, 16'h25C8, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
